// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg
// Shared definitions for the CPU control sequencer. It holds the 3-bit state
// encodings, the opcode values the sequencer decodes, and a helper that
// extracts the opcode field from an instruction word.
// No ports (package).
package cpu_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH      = 3'd0,
    ST_DECODE     = 3'd1,
    ST_EXECUTE    = 3'd2,
    ST_WRITE_BACK = 3'd3,
    ST_HALTED     = 3'd4
  } seq_state_t;

  localparam logic [4:0] OP_MOV  = 5'h01;
  localparam logic [4:0] OP_BR   = 5'h02;
  localparam logic [4:0] OP_HALT = 5'h1f;

  function automatic logic [4:0] opcode_of(input logic [31:0] word);
    return word[31:27];
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if
// Handshake and strobe bundle between the sequencer and the datapath.
//   imem_req/imem_ack/inst : instruction fetch handshake
//   alu_start/alu_done     : ALU launch pulse and completion
//   pc_enable/take_branch  : pc_cntrl controls
//   reg_write_enable       : regbank write strobe
// master = sequencer side, slave = datapath/memory side.
interface cpu_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             imem_req;
  logic             imem_ack;
  logic [WIDTH-1:0] inst;
  logic             alu_start;
  logic             alu_done;
  logic             pc_enable;
  logic             take_branch;
  logic             reg_write_enable;

  modport master (
    output imem_req, alu_start, pc_enable, take_branch, reg_write_enable,
    input  imem_ack, inst, alu_done
  );

  modport slave (
    input  imem_req, alu_start, pc_enable, take_branch, reg_write_enable,
    output imem_ack, inst, alu_done
  );

endinterface

// File: rtl/cpu_sequencer_watchdog.sv
// cpu_sequencer_watchdog
// Counts EXECUTE cycles and flags the cycle on which the MAX_EXEC limit is hit.
//   clk, reset : clock and async active-low reset
//   enable     : high while the sequencer is in EXECUTE
//   clear      : high on the cycle EXECUTE is being left
//   first      : current cycle is the first EXECUTE cycle
//   expire     : current cycle is EXECUTE cycle number MAX_EXEC
module cpu_sequencer_watchdog #(
  parameter int MAX_EXEC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic first,
  output logic expire
);

  localparam int CW = $clog2(MAX_EXEC + 1);

  // The register holds the number of EXECUTE cycles already completed, so
  // the running cycle number is cnt+1 (starting at 1 on the first cycle).
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!enable || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign first  = enable && (cnt == '0);
  assign expire = enable && (cnt == CW'(MAX_EXEC - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Handshaked FETCH/DECODE/EXECUTE/WRITE_BACK control FSM with HALT/resume,
// an EXECUTE watchdog with a sticky fault, and a retired-instruction counter.
//   clk, reset    : clock and async active-low reset
//   run           : 1 = keep executing, 0 = halt at next instruction boundary
//   bus (master)  : fetch handshake, ALU handshake, PC and regbank strobes
//   ir            : latched instruction register
//   state         : current state encoding
//   halted        : state is HALTED
//   fault         : sticky watchdog fault
//   retired_count : instructions completed (wraps)
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 32,
  parameter int MAX_EXEC = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  cpu_sequencer_if.master      bus,
  output logic [WIDTH-1:0]     ir,
  output logic [STATE_W-1:0]   state,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_W-1:0]     retired_count
);

  seq_state_t cur_state;
  seq_state_t next_state;

  logic is_branch;
  logic is_halt;
  logic in_execute;
  logic exec_exit;
  logic wd_first;
  logic wd_expire;
  logic ir_load;
  logic retire;
  logic set_fault;

  assign is_branch  = (opcode_of(ir[31:0]) == OP_BR);
  assign is_halt    = (opcode_of(ir[31:0]) == OP_HALT);
  assign in_execute = (cur_state == ST_EXECUTE);
  // alu_done takes priority over the watchdog, and either one ends EXECUTE.
  assign exec_exit  = in_execute && (bus.alu_done || wd_expire);

  cpu_sequencer_watchdog #(
    .MAX_EXEC (MAX_EXEC)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .enable (in_execute),
    .clear  (exec_exit),
    .first  (wd_first),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state     <= ST_FETCH;
      ir            <= '0;
      fault         <= 1'b0;
      retired_count <= '0;
    end else begin
      cur_state <= next_state;
      if (ir_load) begin
        ir <= bus.inst;
      end
      if (set_fault) begin
        fault <= 1'b1;
      end
      if (retire) begin
        retired_count <= retired_count + CNT_W'(1);
      end
    end
  end

  // Next-state and strobe decode. Strobes are additionally gated by reset so
  // they (imem_req in particular) drop the moment reset asserts rather than
  // waiting for the state register to be observed at FETCH.
  always_comb begin
    next_state           = cur_state;
    ir_load              = 1'b0;
    retire               = 1'b0;
    set_fault            = 1'b0;
    bus.imem_req         = 1'b0;
    bus.alu_start        = 1'b0;
    bus.pc_enable        = 1'b0;
    bus.take_branch      = 1'b0;
    bus.reg_write_enable = 1'b0;

    case (cur_state)
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_load    = 1'b1;
          next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // HALT retires here and advances the PC so resume skips past it.
        if (is_halt) begin
          bus.pc_enable = 1'b1;
          retire        = 1'b1;
          next_state    = ST_HALTED;
        end else begin
          next_state = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        bus.alu_start = wd_first;
        if (bus.alu_done) begin
          next_state = ST_WRITE_BACK;
        end else if (wd_expire) begin
          set_fault  = 1'b1;
          next_state = ST_HALTED;
        end
      end
      ST_WRITE_BACK: begin
        bus.pc_enable        = 1'b1;
        bus.take_branch      = is_branch;
        bus.reg_write_enable = !is_branch;
        retire               = 1'b1;
        next_state           = run ? ST_FETCH : ST_HALTED;
      end
      ST_HALTED: begin
        if (run && !fault) begin
          next_state = ST_FETCH;
        end
      end
      default: begin
        next_state = ST_FETCH;
      end
    endcase

    if (!reset) begin
      bus.imem_req         = 1'b0;
      bus.alu_start        = 1'b0;
      bus.pc_enable        = 1'b0;
      bus.take_branch      = 1'b0;
      bus.reg_write_enable = 1'b0;
    end
  end

  assign state  = cur_state;
  assign halted = (cur_state == ST_HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
// Directed testbench for cpu_sequencer: normal MOV stream, delayed fetch
// acknowledge, branch writeback, multi-cycle ALU, watchdog fault, HALT and
// resume, run deassertion mid-instruction, and asynchronous reset.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam logic [31:0] MOV_A  = 32'h0800_0123;
  localparam logic [31:0] MOV_B  = 32'h0855_aa55;
  localparam logic [31:0] BR_W   = 32'h1000_0040;
  localparam logic [31:0] HALT_W = 32'hf800_0000;
  localparam logic [31:0] JUNK_A = 32'h1234_5678;
  localparam logic [31:0] JUNK_B = 32'hdead_beef;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] ir;
  logic [2:0]  state;
  logic        halted;
  logic        fault;
  logic [31:0] retired_count;

  int tests_run;
  int tests_failed;

  cpu_sequencer_if #(.WIDTH(32)) bus ();

  cpu_sequencer #(
    .WIDTH    (32),
    .CNT_W    (32),
    .MAX_EXEC (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .bus           (bus),
    .ir            (ir),
    .state         (state),
    .halted        (halted),
    .fault         (fault),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic ack,
                                input logic [31:0] word, input logic done);
    run          = r;
    bus.imem_ack = ack;
    bus.inst     = word;
    bus.alu_done = done;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
    tick;
    tick;

    // Reset state
    check_output("rst_state", state, ST_FETCH);
    check_output("rst_imem_req", bus.imem_req, 1'b0);
    check_output("rst_ir", ir, 32'h0);
    check_output("rst_retired", retired_count, 32'h0);
    check_output("rst_fault", fault, 1'b0);
    check_output("rst_halted", halted, 1'b0);

    // Test 1: MOV stream, four cycles per instruction
    apply_stimulus(1'b1, 1'b1, MOV_A, 1'b1);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      check_output("t1_state", state, 64'(i % 4));
      check_output("t1_reg_we", bus.reg_write_enable, 64'((i % 4) == 3));
      check_output("t1_pc_en", bus.pc_enable, 64'((i % 4) == 3));
      check_output("t1_alu_start", bus.alu_start, 64'((i % 4) == 2));
      tick;
    end
    check_output("t1_retired", retired_count, 32'd3);
    check_output("t1_state_end", state, ST_FETCH);

    // Test 2: acknowledge delayed 3 cycles, junk on inst before the ack
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 1'b0, (k % 2 == 0) ? JUNK_A : JUNK_B, 1'b1);
      #1;
      check_output("t2_req_wait", bus.imem_req, 1'b1);
      check_output("t2_state_wait", state, ST_FETCH);
      check_output("t2_ir_wait", ir, MOV_A);
      tick;
    end
    apply_stimulus(1'b1, 1'b1, MOV_B, 1'b1);
    #1;
    check_output("t2_req_ack", bus.imem_req, 1'b1);
    check_output("t2_ir_before", ir, MOV_A);
    tick;
    check_output("t2_state_dec", state, ST_DECODE);
    check_output("t2_ir_latched", ir, MOV_B);
    check_output("t2_req_dec", bus.imem_req, 1'b0);
    apply_stimulus(1'b1, 1'b1, JUNK_A, 1'b1);
    tick;
    check_output("t2_ir_ignore_ack", ir, MOV_B);
    tick;
    tick;
    check_output("t2_retired", retired_count, 32'd4);

    // Test 3: branch writeback
    apply_stimulus(1'b1, 1'b1, BR_W, 1'b1);
    tick;
    tick;
    tick;
    check_output("t3_state_wb", state, ST_WRITE_BACK);
    check_output("t3_take_branch", bus.take_branch, 1'b1);
    check_output("t3_reg_we", bus.reg_write_enable, 1'b0);
    check_output("t3_pc_en", bus.pc_enable, 1'b1);
    tick;
    check_output("t3_branch_off", bus.take_branch, 1'b0);
    check_output("t3_retired", retired_count, 32'd5);

    // Test 4a: six-cycle ALU op, no fault
    apply_stimulus(1'b1, 1'b1, MOV_A, 1'b0);
    tick;
    check_output("t4_dec_alu_start", bus.alu_start, 1'b0);
    tick;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) bus.alu_done = 1'b1;
      #1;
      check_output("t4_exec_state", state, ST_EXECUTE);
      check_output("t4_alu_start", bus.alu_start, 64'(c == 1));
      tick;
    end
    check_output("t4_state_wb", state, ST_WRITE_BACK);
    check_output("t4_no_fault", fault, 1'b0);
    tick;
    check_output("t4_retired", retired_count, 32'd6);

    // Test 4b: ALU never completes, watchdog fires after 16 EXECUTE cycles
    apply_stimulus(1'b1, 1'b1, MOV_A, 1'b0);
    tick;
    tick;
    for (int c = 1; c <= 16; c++) begin
      check_output("t4_wd_state", state, ST_EXECUTE);
      check_output("t4_wd_fault", fault, 1'b0);
      tick;
    end
    check_output("t4_wd_halted_state", state, ST_HALTED);
    check_output("t4_wd_fault_set", fault, 1'b1);
    check_output("t4_wd_halted", halted, 1'b1);
    check_output("t4_wd_retired", retired_count, 32'd6);
    check_output("t4_wd_no_we", bus.reg_write_enable, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick;
      check_output("t4_fault_sticky", state, ST_HALTED);
    end
    reset = 1'b0;
    #1;
    check_output("t4_rst_state", state, ST_FETCH);
    check_output("t4_rst_fault", fault, 1'b0);
    check_output("t4_rst_retired", retired_count, 32'h0);

    // Test 5: HALT opcode, resume, run dropped mid-instruction
    apply_stimulus(1'b1, 1'b1, HALT_W, 1'b1);
    tick;
    reset = 1'b1;
    #1;
    check_output("t5_fetch", state, ST_FETCH);
    tick;
    check_output("t5_dec_state", state, ST_DECODE);
    check_output("t5_dec_pc_en", bus.pc_enable, 1'b1);
    check_output("t5_dec_reg_we", bus.reg_write_enable, 1'b0);
    check_output("t5_dec_retired", retired_count, 32'h0);
    tick;
    check_output("t5_halted", state, ST_HALTED);
    check_output("t5_retired", retired_count, 32'd1);
    check_output("t5_halt_pc_en", bus.pc_enable, 1'b0);
    apply_stimulus(1'b0, 1'b1, MOV_A, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick;
      check_output("t5_stay_halted", state, ST_HALTED);
    end
    run = 1'b1;
    #1;
    check_output("t5_resume_wait", state, ST_HALTED);
    tick;
    check_output("t5_resume_fetch", state, ST_FETCH);
    tick;
    tick;
    run = 1'b0;
    tick;
    check_output("t5_run0_wb", state, ST_WRITE_BACK);
    check_output("t5_run0_we", bus.reg_write_enable, 1'b1);
    tick;
    check_output("t5_run0_halted", state, ST_HALTED);
    check_output("t5_run0_retired", retired_count, 32'd2);

    // Test 6: asynchronous reset in EXECUTE and in FETCH
    apply_stimulus(1'b1, 1'b1, MOV_A, 1'b0);
    tick;
    tick;
    tick;
    tick;
    check_output("t6_exec_state", state, ST_EXECUTE);
    #2;
    reset = 1'b0;
    bus.alu_done = 1'b1;
    #1;
    check_output("t6_rst_exec_state", state, ST_FETCH);
    check_output("t6_rst_exec_we", bus.reg_write_enable, 1'b0);
    check_output("t6_rst_exec_pc", bus.pc_enable, 1'b0);
    check_output("t6_rst_exec_ir", ir, 32'h0);
    check_output("t6_rst_exec_retired", retired_count, 32'h0);
    tick;
    check_output("t6_rst_hold_we", bus.reg_write_enable, 1'b0);
    apply_stimulus(1'b1, 1'b0, MOV_B, 1'b1);
    reset = 1'b1;
    #1;
    check_output("t6_release_state", state, ST_FETCH);
    check_output("t6_release_req", bus.imem_req, 1'b1);
    tick;
    check_output("t6_fetch_stall", state, ST_FETCH);
    #2;
    reset = 1'b0;
    #1;
    check_output("t6_rst_fetch_req", bus.imem_req, 1'b0);
    tick;
    reset = 1'b1;
    #1;
    check_output("t6_after_state", state, ST_FETCH);
    check_output("t6_after_req", bus.imem_req, 1'b1);
    check_output("t6_after_ir", ir, 32'h0);
    bus.imem_ack = 1'b1;
    tick;
    check_output("t6_after_dec", state, ST_DECODE);
    check_output("t6_after_ir_load", ir, MOV_B);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Control sequencer for the four-phase CPU datapath: FETCH, DECODE, EXECUTE, WRITE_BACK. It replaces the free-running state counter with a handshaked FSM.
- Fetch waits on instruction-memory acknowledge.
- Execute waits on ALU completion, so multi-cycle ops are supported.
- Adds HALT/resume, a watchdog fault and a retired-instruction counter.
- It owns the instruction register and drives pc_cntrl enable/branch and the regbank write enable.

Parameters:
WIDTH, 32, instruction/data width
CNT_W, 32, retired-instruction counter width
MAX_EXEC, 16, max EXECUTE cycles before watchdog fault (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
run  in  1  level; 1 = keep executing, 0 = stop at next instruction boundary / stay halted
imem_req  out  1  fetch request to instruction memory
imem_ack  in  1  fetch acknowledge; inst valid in the same cycle
inst  in  WIDTH  instruction word from memory
ir  out  WIDTH  latched instruction register
state  out  3  current state (encodings from defines.vh)
alu_start  out  1  one-cycle pulse at first EXECUTE cycle
alu_done  in  1  ALU result valid (single-cycle ALU ties high)
pc_enable  out  1  advance PC (pc_cntrl enable)
take_branch  out  1  branch select to pc_cntrl
reg_write_enable  out  1  regbank write strobe
halted  out  1  state == HALTED
fault  out  1  sticky watchdog fault
retired_count  out  CNT_W  instructions completed

Behaviour:
- Reset (reset=0, async): state=FETCH, ir=0, retired_count=0, fault=0, exec counter=0, all strobes 0; imem_req drops immediately. Reset mid-fetch or mid-execute abandons the instruction; no partial writeback.
- opcode = ir[31:27]. is_branch = opcode==`BR`. is_halt = opcode==`HALT`.
- FETCH:
  - imem_req=1 every FETCH cycle.
  - On imem_ack=1: ir<=inst, next DECODE.
  - Minimum 1 cycle; stalls indefinitely without ack.
  - imem_ack in any other state is ignored.
- DECODE: 1 cycle.
  - is_halt: pc_enable=1 this cycle (resume continues at next instruction), retired_count+1, next HALTED.
  - Otherwise: next EXECUTE.
- EXECUTE:
  - alu_start=1 only on the first cycle. Exec counter starts at 1 and increments each cycle.
  - alu_done=1 in any EXECUTE cycle (including the first) -> WRITE_BACK.
  - If counter==MAX_EXEC and alu_done=0: fault<=1, next HALTED. Counter clears on exit.
- WRITE_BACK: 1 cycle.
  - pc_enable=1, take_branch=is_branch, reg_write_enable=!is_branch.
  - retired_count+1 (wraps modulo 2^CNT_W).
  - Next FETCH if run=1, else HALTED.
- HALTED:
  - All strobes 0.
  - run=1 and fault=0 -> FETCH next cycle.
  - fault=1: stays HALTED until reset; run is ignored.
- All strobes are combinational from state plus registered ir/counters. All are 0 outside their stated state.
- run is sampled only in WRITE_BACK and HALTED. Deasserting run mid-instruction completes that instruction.
- Simultaneous alu_done=1 and watchdog limit in the same cycle: alu_done wins (WRITE_BACK, no fault).

Decomposition:
- defines.vh gains 3-bit state encodings FETCH=0, DECODE=1, EXECUTE=2, WRITE_BACK=3, HALTED=4; opcode `HALT`; STATE_W=3.
- The existing `BR`/`MOV` opcodes stay there.
- One natural sub-module: seq_watchdog (exec-cycle counter + limit compare, clear/enable inputs, expire output).
- cpu instantiates cpu_sequencer in place of its inline state counter.

Test Plan:
1. Reset release, run=1, imem_ack tied 1, alu_done tied 1, MOV stream -> each instruction takes exactly 4 cycles (FETCH,DECODE,EXECUTE,WRITE_BACK); reg_write_enable/pc_enable pulse once per 4 cycles; retired_count=3 after 12 cycles.
2. imem_ack delayed 3 cycles -> imem_req high 4 cycles, ir unchanged until the ack cycle, then DECODE; inst toggling before the ack never reaches ir.
3. BR instruction -> WRITE_BACK with take_branch=1, reg_write_enable=0, pc_enable=1.
4. alu_done low 5 cycles, MAX_EXEC=16 -> alu_start high exactly 1 cycle, 6 EXECUTE cycles, no fault. Then alu_done held 0 -> fault=1 after 16 EXECUTE cycles, HALTED, run=1 has no effect until reset.
5. HALT opcode -> DECODE->HALTED with pc_enable pulse, retired_count+1. run held 0 for 10 cycles stays HALTED; run=1 -> FETCH next cycle. run=0 during EXECUTE -> instruction completes, then HALTED.
6. reset asserted in EXECUTE and in FETCH (with imem_req high) -> outputs reset asynchronously before the next clk edge, no reg_write_enable pulse, FETCH after release.
